tnoc_axi_read_outstanding_limiter: RTL
======================================

TNOC_AXI_READ_OUTSTANDING_LIMITER -- requirements
Module: tnoc_axi_read_outstanding_limiter

Position: between an AXI read master and the AXI slave read adapter; AR buffered and throttled, R passed through.

Interface
REQ-001 SHALL have parameter CONFIG, default TNOC_DEFAULT_CONFIG, meaning NoC/AXI configuration (address, id, data and length widths).
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 8, meaning maximum issued reads without final beat (legal 1..255).
REQ-003 SHALL have localparam COUNT_WIDTH = $clog2(MAX_OUTSTANDING+1).
REQ-004 clk  input  1  clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 i_drain  input  1  when high, no new AR accepted from upstream.
REQ-007 axi_in_if  tnoc_axi_read_if.slave  CONFIG widths  upstream master side.
REQ-008 axi_out_if  tnoc_axi_read_if.master  CONFIG widths  downstream, to the slave read adapter.
REQ-009 o_outstanding  output  COUNT_WIDTH  current outstanding read count.
REQ-010 o_idle  output  1  high when outstanding count is 0 and AR buffer is empty.
REQ-011 o_error  output  1  one-cycle pulse on an unexpected R last beat.

Function
REQ-012 AR path SHALL be a 2-entry FIFO (skid buffer) holding arid, araddr, arlen, arsize, arburst as one entry.
REQ-013 axi_in_if.arready SHALL equal (entries < 2) && !i_drain, derived only from registered state and i_drain, with no combinational path from axi_out_if.arready.
REQ-014 Entry SHALL be written on axi_in_if.arvalid && axi_in_if.arready.
REQ-015 Head entry SHALL be presented on axi_out_if AR fields; axi_out_if.arvalid = (entries != 0) && (count < MAX_OUTSTANDING).
REQ-016 Once axi_out_if.arvalid is high, it and the AR fields SHALL stay stable until handshake; guaranteed because count never increases except on AR handshake.
REQ-017 Entry SHALL be popped on axi_out_if.arvalid && axi_out_if.arready.
REQ-018 Simultaneous push and pop SHALL keep entry count unchanged and preserve order.
REQ-019 count SHALL increment by 1 on a downstream AR handshake.
REQ-020 count SHALL decrement by 1 on axi_out_if.rvalid && rready && rlast.
REQ-021 Both increment and decrement in the same cycle SHALL leave count unchanged.
REQ-022 Last-beat handshake while count == 0 with no same-cycle AR handshake SHALL leave count at 0 and assert o_error for exactly the next cycle.
REQ-023 R channel SHALL be combinational pass-through: rvalid, rid, rdata, rresp, rlast forward to axi_in_if; rready forwards to axi_out_if; zero latency, no modification.
REQ-024 i_drain SHALL NOT affect entries already buffered or R traffic; buffered entries still issue subject to REQ-015.
REQ-025 o_outstanding SHALL equal the count register; o_idle SHALL be combinational from registered count and entry count.
REQ-026 arlen SHALL NOT affect count; one transaction equals one count regardless of burst length.

Reset
REQ-027 On rst_n low: entries=0, count=0, o_error=0; axi_out_if.arvalid=0, o_outstanding=0, o_idle=1; axi_in_if.arready=!i_drain.
REQ-028 Reset assertion mid-transaction SHALL discard buffered ARs and count immediately, asynchronously.

Verification (MAX_OUTSTANDING=2)
REQ-029 Three back-to-back ARs (ids 1,2,3), downstream arready=1, no R -> ids 1,2 issued, o_outstanding=2, id 3 held with out arvalid=0, in arready=1 (1 entry).
REQ-030 Continue: R beat id 1 with rlast=1 -> next cycle out arvalid=1 for id 3; after handshake o_outstanding stays 2.
REQ-031 Downstream arready=0, 3 upstream ARs -> in arready drops after 2 entries; out arvalid and fields stable until arready=1; issue order 1,2.
REQ-032 count=1, same-cycle AR handshake and rlast handshake -> o_outstanding stays 1.
REQ-033 count=0, R rlast beat injected -> o_error high one cycle, o_outstanding=0.
REQ-034 i_drain=1 with 1 buffered entry and count=1 -> in arready=0, entry issues, two rlast beats -> o_idle=1.

Source files
------------

// File: rtl/tnoc_axi_read_outstanding_limiter_if.sv
// tnoc_axi_read_outstanding_limiter_if: NoC/AXI configuration package and AXI read channel bundle
// shared by the outstanding-read limiter and its neighbours.
package tnoc_axi_pkg;
    typedef struct packed {
        int addr_width;
        int id_width;
        int data_width;
        int length_width;
    } tnoc_config;

    localparam tnoc_config TNOC_DEFAULT_CONFIG = '{
        addr_width:   32,
        id_width:     4,
        data_width:   32,
        length_width: 8
    };
endpackage

interface tnoc_axi_read_if #(
    parameter tnoc_axi_pkg::tnoc_config CONFIG = tnoc_axi_pkg::TNOC_DEFAULT_CONFIG
);
    localparam int IDW = CONFIG.id_width;
    localparam int AW  = CONFIG.addr_width;
    localparam int DW  = CONFIG.data_width;
    localparam int LW  = CONFIG.length_width;

    logic           arvalid;
    logic           arready;
    logic [IDW-1:0] arid;
    logic [AW-1:0]  araddr;
    logic [LW-1:0]  arlen;
    logic [2:0]     arsize;
    logic [1:0]     arburst;
    logic           rvalid;
    logic           rready;
    logic [IDW-1:0] rid;
    logic [DW-1:0]  rdata;
    logic [1:0]     rresp;
    logic           rlast;

    modport master (
        output arvalid, arid, araddr, arlen, arsize, arburst, rready,
        input  arready, rvalid, rid, rdata, rresp, rlast
    );

    modport slave (
        input  arvalid, arid, araddr, arlen, arsize, arburst, rready,
        output arready, rvalid, rid, rdata, rresp, rlast
    );
endinterface

// File: rtl/tnoc_axi_read_outstanding_limiter.sv
// tnoc_axi_read_outstanding_limiter: buffers AR in a 2-entry skid FIFO and only issues while fewer than
// MAX_OUTSTANDING reads await their last R beat; R is a zero-latency pass-through.
module tnoc_axi_read_outstanding_limiter #(
    parameter tnoc_axi_pkg::tnoc_config CONFIG          = tnoc_axi_pkg::TNOC_DEFAULT_CONFIG,
    parameter int                       MAX_OUTSTANDING = 8,
    localparam int                      COUNT_WIDTH     = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_drain,
    tnoc_axi_read_if.slave         axi_in_if,
    tnoc_axi_read_if.master        axi_out_if,
    output logic [COUNT_WIDTH-1:0] o_outstanding,
    output logic                   o_idle,
    output logic                   o_error
);
    localparam int IDW = CONFIG.id_width;
    localparam int AW  = CONFIG.addr_width;
    localparam int LW  = CONFIG.length_width;
    localparam int EW  = IDW + AW + LW + 3 + 2;
    localparam logic [COUNT_WIDTH-1:0] MAX_CNT = COUNT_WIDTH'(MAX_OUTSTANDING);

    logic [EW-1:0]          entry_q [2];
    logic [EW-1:0]          in_entry;
    logic [1:0]             entries_q, entries_d;
    logic                   wr_ptr_q, rd_ptr_q;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   error_q, error_d;
    logic                   push, pop, last_beat;

    assign in_entry  = {axi_in_if.arid, axi_in_if.araddr, axi_in_if.arlen, axi_in_if.arsize, axi_in_if.arburst};
    assign push      = axi_in_if.arvalid && axi_in_if.arready;
    assign pop       = axi_out_if.arvalid && axi_out_if.arready;
    assign last_beat = axi_out_if.rvalid && axi_out_if.rready && axi_out_if.rlast;

    // Upstream ready depends only on registered occupancy, breaking the arready path.
    assign axi_in_if.arready  = (entries_q != 2'd2) && !i_drain;
    assign axi_out_if.arvalid = (entries_q != 2'd0) && (count_q < MAX_CNT);
    assign {axi_out_if.arid, axi_out_if.araddr, axi_out_if.arlen, axi_out_if.arsize, axi_out_if.arburst} = entry_q[rd_ptr_q];

    assign axi_in_if.rvalid  = axi_out_if.rvalid;
    assign axi_in_if.rid     = axi_out_if.rid;
    assign axi_in_if.rdata   = axi_out_if.rdata;
    assign axi_in_if.rresp   = axi_out_if.rresp;
    assign axi_in_if.rlast   = axi_out_if.rlast;
    assign axi_out_if.rready = axi_in_if.rready;

    assign o_outstanding = count_q;
    assign o_idle        = (count_q == '0) && (entries_q == 2'd0);
    assign o_error       = error_q;

    always_comb begin
        entries_d = entries_q;
        count_d   = count_q;
        error_d   = 1'b0;
        if (push && !pop) entries_d = entries_q + 2'd1;
        else if (pop && !push) entries_d = entries_q - 2'd1;
        if (pop && !last_beat) count_d = count_q + COUNT_WIDTH'(1);
        else if (last_beat && !pop) begin
            if (count_q == '0) error_d = 1'b1;
            else count_d = count_q - COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entries_q <= 2'd0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= '0;
            error_q   <= 1'b0;
        end else begin
            entries_q <= entries_d;
            wr_ptr_q  <= wr_ptr_q ^ push;
            rd_ptr_q  <= rd_ptr_q ^ pop;
            count_q   <= count_d;
            error_q   <= error_d;
        end
    end

    // Payload storage needs no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (push) entry_q[wr_ptr_q] <= in_entry;
    end
endmodule
